// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM states,
// UART register offsets and the per-packet byte limit.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      POLL,
      CHECK,
      WRITE
   } state_t;

   localparam logic [31:0] TX_STATE  = 32'd8;
   localparam logic [31:0] TX_DATA   = 32'd12;
   localparam int          MAX_BYTES = 3;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin pick: the first requester after 'last' (wrapping at
// N-1) whose request bit is set wins; all-zero when nothing is requested.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  pick
);

   // Walk the distances from farthest to nearest so the nearest hit overwrites.
   always_comb begin
      pick = '0;
      for (int k = N; k >= 1; k--) begin
         int idx;
         idx = int'(last) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) pick = {{(N-1){1'b0}}, 1'b1} << idx;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Collects up to three bytes from one of NUM_REQ requesters, polls the UART
// until the transmitter is done, then writes the packet. Build option
// UART_ARB_PRIO_EN gives requester 0 absolute priority over the others.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int          NUM_REQ   = 4,
   parameter logic [31:0] UART_BASE = 32'h0
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 ren,
   output logic                 wen,
   output logic [31:0]          addr,
   output logic [31:0]          wdata,
   output logic [3:0]           strobe,
   input  logic [31:0]          rdata,
   input  logic                 request_stall
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t              state;
   logic [1:0]          count;
   logic [7:0]          data0;
   logic [7:0]          data1;
   logic [7:0]          data2;
   logic [IW-1:0]       last_grant;

   logic [NUM_REQ-1:0]  rr_req;
   logic [NUM_REQ-1:0]  rr_pick;
   logic [NUM_REQ-1:0]  win;
   logic                own_valid;
   logic                own_last;
   logic [7:0]          own_data;
   logic [IW-1:0]       own_idx;
   logic                accept;
   logic                unused_rdata;

   assign unused_rdata = ^rdata[31:1];

`ifdef UART_ARB_PRIO_EN
   assign rr_req = req_valid & ~{{(NUM_REQ-1){1'b0}}, 1'b1};
   assign win    = req_valid[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : rr_pick;
`else
   assign rr_req = req_valid;
   assign win    = rr_pick;
`endif

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .req  (rr_req),
      .last (last_grant),
      .pick (rr_pick)
   );

   always_comb begin
      own_valid = |(req_valid & grant);
      own_last  = |(req_last & grant);
      own_data  = '0;
      own_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            own_data = req_data[8*i +: 8];
            own_idx  = IW'(i);
         end
      end
   end

   assign accept    = (state == COLLECT) && own_valid && (count != 2'(MAX_BYTES));
   assign req_ready = ((state == COLLECT) && (count != 2'(MAX_BYTES))) ? grant : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         count      <= '0;
         data0      <= '0;
         data1      <= '0;
         data2      <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         grant      <= '0;
         ren        <= 1'b0;
         wen        <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         strobe     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant <= win;
                  count <= '0;
                  data0 <= '0;
                  data1 <= '0;
                  data2 <= '0;
                  state <= COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  case (count)
                     2'd0:    data0 <= own_data;
                     2'd1:    data1 <= own_data;
                     default: data2 <= own_data;
                  endcase
                  count <= count + 2'd1;
                  if (count == 2'(MAX_BYTES - 1) || own_last) begin
                     ren   <= 1'b1;
                     addr  <= UART_BASE + TX_STATE;
                     state <= POLL;
                  end
               end else if (count != 2'd0) begin
                  // Owner went quiet after at least one byte: ship what we have.
                  ren   <= 1'b1;
                  addr  <= UART_BASE + TX_STATE;
                  state <= POLL;
               end
            end
            POLL: begin
               if (!request_stall) begin
                  ren   <= 1'b0;
                  addr  <= '0;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (rdata[0]) begin
                  wen    <= 1'b1;
                  addr   <= UART_BASE + TX_DATA;
                  strobe <= 4'hF;
                  wdata  <= {6'b0, count, data2, data1, data0};
                  state  <= WRITE;
               end else begin
                  ren   <= 1'b1;
                  addr  <= UART_BASE + TX_STATE;
                  state <= POLL;
               end
            end
            WRITE: begin
               if (!request_stall) begin
                  wen        <= 1'b0;
                  addr       <= '0;
                  wdata      <= '0;
                  strobe     <= '0;
                  last_grant <= own_idx;
                  grant      <= '0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a bus monitor logs accepted reads and
// writes, and each scenario compares the log against hand-computed values.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             nReset;
   logic [N-1:0]     req_valid;
   logic [N*8-1:0]   req_data;
   logic [N-1:0]     req_last;
   wire  [N-1:0]     req_ready;
   wire  [N-1:0]     grant;
   wire              busy;
   wire              ren;
   wire              wen;
   wire  [31:0]      addr;
   wire  [31:0]      wdata;
   wire  [3:0]       strobe;
   wire  [31:0]      rdata;
   logic             request_stall;

   int n_chk = 0;
   int n_pass = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int overlap = 0;
   int bad_idle = 0;
   int done_thr = 0;

   logic [31:0]  wr_addr  [32];
   logic [31:0]  wr_data  [32];
   logic [3:0]   wr_strb  [32];
   logic [N-1:0] wr_grant [32];

   uart_tx_arbiter #(.NUM_REQ(N), .UART_BASE(32'h0)) dut (
      .clk           (clk),
      .nReset        (nReset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .grant         (grant),
      .busy          (busy),
      .ren           (ren),
      .wen           (wen),
      .addr          (addr),
      .wdata         (wdata),
      .strobe        (strobe),
      .rdata         (rdata),
      .request_stall (request_stall)
   );

   always #5 clk = ~clk;

   // UART status model: transmitter reports done once rd_cnt reaches done_thr.
   assign rdata = {31'b0, (rd_cnt >= done_thr)};

   always @(posedge clk) begin
      if (ren && !request_stall) rd_cnt <= rd_cnt + 1;
      if (wen && !request_stall && wr_cnt < 32) begin
         wr_addr[wr_cnt]  <= addr;
         wr_data[wr_cnt]  <= wdata;
         wr_strb[wr_cnt]  <= strobe;
         wr_grant[wr_cnt] <= grant;
         wr_cnt           <= wr_cnt + 1;
      end
      if (ren && wen) overlap <= overlap + 1;
      if (!ren && !wen && (addr != 32'h0 || wdata != 32'h0 || strobe != 4'h0))
         bad_idle <= bad_idle + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input int r, input logic [7:0] d, input logic l);
      int t = 0;
      req_valid[r]     = 1'b1;
      req_data[8*r +: 8] = d;
      req_last[r]      = l;
      while (!req_ready[r] && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready[r]) chk("ready_timeout", 32'(req_ready[r]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   task automatic wait_wr(input int n);
      int t = 0;
      while (wr_cnt < n && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("write_count", 32'(wr_cnt), 32'(n));
   endtask

   task automatic do_reset();
      nReset = 1'b0;
      repeat (2) @(negedge clk);
      nReset = 1'b1;
   endtask

   logic [N-1:0] exp_g [6];
   logic [31:0]  exp_d [6];

   initial begin
      int w0;
      int r0;
      int t;
      nReset        = 1'b1;
      req_valid     = '0;
      req_data      = '0;
      req_last      = '0;
      request_stall = 1'b0;
      #2 nReset = 1'b0;
      #1;
      chk("rst_grant",  32'(grant),     32'h0);
      chk("rst_busy",   32'(busy),      32'h0);
      chk("rst_ren",    32'(ren),       32'h0);
      chk("rst_wen",    32'(wen),       32'h0);
      chk("rst_bus",    addr | wdata | 32'(strobe), 32'h0);
      chk("rst_ready",  32'(req_ready), 32'h0);
      @(negedge clk);
      @(negedge clk);
      nReset = 1'b1;

      // Three-byte packet from requester 1
      w0 = wr_cnt;
      r0 = rd_cnt;
      send(1, 8'h41, 1'b0);
      send(1, 8'h42, 1'b0);
      send(1, 8'h43, 1'b1);
      wait_wr(w0 + 1);
      chk("p1_addr",  wr_addr[w0],          32'd12);
      chk("p1_data",  wr_data[w0],          32'h03434241);
      chk("p1_strb",  32'(wr_strb[w0]),     32'hF);
      chk("p1_grant", 32'(wr_grant[w0]),    32'h2);
      chk("p1_reads", 32'(rd_cnt - r0),     32'd1);
      repeat (3) @(negedge clk);
      chk("p1_single", 32'(wr_cnt - w0),    32'd1);
      chk("p1_idle",   32'({busy, grant}),  32'h0);

      // Requesters 0 and 2 together straight out of reset
      do_reset();
      w0 = wr_cnt;
      fork
         send(0, 8'hA0, 1'b1);
         send(2, 8'hA2, 1'b1);
      join
      wait_wr(w0 + 2);
      chk("rr_g0", 32'(wr_grant[w0]),     32'h1);
      chk("rr_d0", wr_data[w0],           32'h010000A0);
      chk("rr_g1", 32'(wr_grant[w0 + 1]), 32'h4);
      chk("rr_d1", wr_data[w0 + 1],       32'h010000A2);

      // Transmitter busy for three polls
      w0 = wr_cnt;
      r0 = rd_cnt;
      done_thr = rd_cnt + 4;
      send(3, 8'h55, 1'b1);
      wait_wr(w0 + 1);
      chk("poll_reads", 32'(rd_cnt - r0), 32'd4);
      chk("poll_data",  wr_data[w0],      32'h01000055);
      done_thr = 0;

      // Owner drops valid after two bytes
      w0 = wr_cnt;
      send(2, 8'h11, 1'b0);
      send(2, 8'h22, 1'b0);
      wait_wr(w0 + 1);
      chk("gap_data", wr_data[w0], 32'h02002211);

      // Five stalled write cycles
      w0 = wr_cnt;
      send(1, 8'h77, 1'b1);
      t = 0;
      while (!wen && t < 200) begin
         @(negedge clk);
         t++;
      end
      request_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_wen",  32'(wen), 32'd1);
         chk("stall_addr", addr,     32'd12);
         chk("stall_data", wdata,    32'h01000077);
         @(negedge clk);
      end
      chk("stall_nowr", 32'(wr_cnt - w0), 32'd0);
      request_stall = 1'b0;
      repeat (2) @(negedge clk);
      chk("stall_once", 32'(wr_cnt - w0), 32'd1);
      chk("stall_wen_off", 32'(wen), 32'd0);

      // Reset in the middle of collection
      w0 = wr_cnt;
      send(2, 8'hC1, 1'b0);
      send(2, 8'hC2, 1'b0);
      nReset = 1'b0;
      #1;
      chk("mid_busy",  32'(busy),             32'h0);
      chk("mid_grant", 32'(grant),            32'h0);
      chk("mid_bus",   32'({ren, wen}) | addr | wdata, 32'h0);
      repeat (3) @(negedge clk);
      nReset = 1'b1;
      chk("mid_nowr",  32'(wr_cnt - w0),      32'd0);
      fork
         send(0, 8'hD0, 1'b1);
         send(1, 8'hD1, 1'b1);
      join
      wait_wr(w0 + 2);
      chk("mid_g0", 32'(wr_grant[w0]), 32'h1);
      chk("mid_d0", wr_data[w0],       32'h010000D0);

      // Requesters 0 and 3 continuously valid
`ifdef UART_ARB_PRIO_EN
      exp_g = '{4'h1, 4'h1, 4'h1, 4'h8, 4'h8, 4'h8};
      exp_d = '{32'h010000E0, 32'h010000E1, 32'h010000E2,
                32'h010000F0, 32'h010000F1, 32'h010000F2};
`else
      exp_g = '{4'h1, 4'h8, 4'h1, 4'h8, 4'h1, 4'h8};
      exp_d = '{32'h010000E0, 32'h010000F0, 32'h010000E1,
                32'h010000F1, 32'h010000E2, 32'h010000F2};
`endif
      do_reset();
      w0 = wr_cnt;
      fork
         begin
            send(0, 8'hE0, 1'b1);
            send(0, 8'hE1, 1'b1);
            send(0, 8'hE2, 1'b1);
         end
         begin
            send(3, 8'hF0, 1'b1);
            send(3, 8'hF1, 1'b1);
            send(3, 8'hF2, 1'b1);
         end
      join
      wait_wr(w0 + 6);
      for (int i = 0; i < 6; i++) begin
         chk("arb_grant", 32'(wr_grant[w0 + i]), 32'(exp_g[i]));
         chk("arb_data",  wr_data[w0 + i],       exp_d[i]);
      end

      chk("ren_wen_overlap", 32'(overlap),  32'd0);
      chk("idle_bus_zero",   32'(bad_idle), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got %0d writes", wr_cnt);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter SHALL be: NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter SHALL be: UART_BASE, default 32'h0, base address of the UART register block.
REQ-003 Port SHALL be: clk  input  1  clock; all logic on its rising edge.
REQ-004 Port SHALL be: nReset  input  1  reset, asynchronous, active-low.
REQ-005 Port SHALL be: req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 Port SHALL be: req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 Port SHALL be: req_last  input  NUM_REQ  marks the current byte as the packet end.
REQ-008 Port SHALL be: req_ready  output  NUM_REQ  byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 Port SHALL be: grant  output  NUM_REQ  one-hot owner of the current packet; all-zero when idle.
REQ-010 Port SHALL be: busy  output  1  high in every state except IDLE.
REQ-011 Ports SHALL be the bus-master side: ren, wen (output 1), addr (output 32), wdata (output 32), strobe (output 4), rdata (input 32), request_stall (input 1).

Function
REQ-012 FSM states SHALL be IDLE, COLLECT, POLL, CHECK, WRITE.
REQ-013 IDLE: on any req_valid high, the arbiter SHALL grant the round-robin winner (search starting at last_grant+1, wrapping at NUM_REQ-1), then enter COLLECT the next cycle.
REQ-014 COLLECT: req_ready SHALL be high only for the granted requester; each accepted byte SHALL be stored at index count (first byte is byte0), count increments.
REQ-015 COLLECT SHALL exit to POLL when count reaches 3, when a byte with req_last is accepted, or when req_valid of the owner is low for one cycle with count>=1.
REQ-016 POLL: ren=1, addr=UART_BASE+8, held until a cycle with request_stall low; then go to CHECK.
REQ-017 CHECK: rdata[0] (transmitter done) SHALL be sampled; 1 -> WRITE, 0 -> POLL.
REQ-018 WRITE: wen=1, addr=UART_BASE+12, strobe=4'hF, wdata={count, byte2, byte1, byte0}; unused bytes zero; held while request_stall is high.
REQ-019 After the accepted WRITE, last_grant SHALL update to the owner, grant SHALL clear, and the FSM SHALL return to IDLE.
REQ-020 ren and wen SHALL never be high in the same cycle; addr/wdata/strobe SHALL be zero when neither is high.
REQ-021 count SHALL be 2 bits, range 0..3; no byte SHALL be accepted when count==3.
REQ-022 A requester deasserting req_valid before its first byte is accepted SHALL keep the grant; COLLECT waits.
REQ-023 New requests arriving during POLL/CHECK/WRITE SHALL not change grant.

Reset
REQ-024 On nReset low, all outputs SHALL be 0, the state SHALL be IDLE, count 0, stored bytes 0, last_grant NUM_REQ-1 (so requester 0 wins first).
REQ-025 Reset mid-packet SHALL discard the partial packet; no bus write SHALL occur for it.

Configuration
REQ-026 Macro UART_ARB_PRIO_EN SHALL select arbitration: when defined, requester 0 SHALL win whenever its req_valid is high in IDLE, otherwise round-robin among the rest; when undefined, pure round-robin over all requesters.

Structure
REQ-027 Package uart_arb_pkg SHALL hold the state enum, register offsets (TX_STATE=8, TX_DATA=12), and MAX_BYTES=3.
REQ-028 Sub-module rr_arbiter SHALL implement the one-hot round-robin pick from a request vector and last_grant.

Verification
REQ-029 Requester 1 sends 8'h41,8'h42,8'h43 with last on 8'h43, rdata[0]=1 -> one write, addr 12, wdata 32'h03434241.
REQ-030 Requesters 0 and 2 valid together from reset -> grant 0 first, then 2; two writes in that order.
REQ-031 Single byte 8'h55 with last, rdata[0]=0 for three polls then 1 -> four POLL reads, then wdata 32'h01000055.
REQ-032 request_stall high 5 cycles during WRITE -> wen/addr/wdata stable all 5 cycles, exactly one write accepted.
REQ-033 nReset asserted after 2 bytes collected -> outputs 0 immediately, no write; next packet starts from requester 0.
REQ-034 With UART_ARB_PRIO_EN, requesters 0 and 3 continuously valid -> requester 0 granted every packet.
